// File: rtl/soric_mem_pkg.sv
// ---------------------------------------------------------------------------
// soric_mem_pkg: shared widths, WB FSM encoding and requester IDs.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package soric_mem_pkg;

    localparam int SRAM_ADDR_W = 8;
    localparam int SRAM_DATA_W = 32;

    typedef enum logic [2:0] {
        WB_IDLE    = 3'd0,
        WB_WAIT_RD = 3'd1,
        WB_ACK_RD  = 3'd2,
        WB_ACK_WR  = 3'd3,
        WB_HOLD    = 3'd4
    } wb_state_t;

    localparam logic REQ_WB   = 1'b0;
    localparam logic REQ_CORE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/soric_rr_arb2.sv
// ---------------------------------------------------------------------------
// soric_rr_arb2: 2-input round-robin arbiter, registered last winner.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module soric_rr_arb2
    import soric_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (last == REQ_WB) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end
    end

    // Reset to "core won last" so the Wishbone side is preferred first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= REQ_CORE;
        end else if (|req) begin
            last <= gnt[1] ? REQ_CORE : REQ_WB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/soric_sram_arbiter.sv
// ---------------------------------------------------------------------------
// soric_sram_arbiter: shares one SRAM macro between Wishbone and core.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module soric_sram_arbiter
    import soric_mem_pkg::*;
#(
    parameter int          ADDR_W  = SRAM_ADDR_W,
    parameter int          DATA_W  = SRAM_DATA_W,
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    parameter logic [31:0] WB_MASK = 32'hFFFF_FC00
) (
    input  logic                wb_clk_i,
    input  logic                resetb,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [DATA_W/8-1:0] core_be,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                sram_csb0,
    output logic                sram_web0,
    output logic [DATA_W/8-1:0] sram_wmask0,
    output logic [ADDR_W-1:0]   sram_addr0,
    output logic [DATA_W-1:0]   sram_din0,
    input  logic [DATA_W-1:0]   sram_dout0
);

    wb_state_t         state;
    wb_state_t         state_nxt;
    logic              wb_hit;
    logic              wb_req;
    logic              wb_gnt;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] wb_word;
    logic              core_rd_p1;
    logic              core_rd_p2;

    assign wb_hit  = wbs_cyc_i & wbs_stb_i &
                     ((wbs_adr_i & WB_MASK) == (WB_BASE & WB_MASK));
    assign wb_req  = (state == WB_IDLE) & wb_hit;
    assign wb_word = wbs_adr_i[ADDR_W+1:2];

    assign req[REQ_WB]   = wb_req;
    assign req[REQ_CORE] = core_req;
    assign wb_gnt        = gnt[REQ_WB];
    assign core_gnt      = gnt[REQ_CORE];

    soric_rr_arb2 u_arb (
        .clk   (wb_clk_i),
        .rst_n (resetb),
        .req   (req),
        .gnt   (gnt)
    );

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE:    if (wb_gnt) state_nxt = wbs_we_i ? WB_ACK_WR : WB_WAIT_RD;
            WB_WAIT_RD: state_nxt = WB_ACK_RD;
            WB_ACK_RD:  state_nxt = WB_HOLD;
            WB_ACK_WR:  state_nxt = WB_HOLD;
            WB_HOLD:    state_nxt = WB_IDLE;
            default:    state_nxt = WB_IDLE;
        endcase
    end

    // Macro port registers: the winner of this edge owns the next macro cycle.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else if (wb_gnt) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= ~wbs_we_i;
            sram_wmask0 <= wbs_we_i ? wbs_sel_i : '0;
            sram_addr0  <= wb_word;
            sram_din0   <= wbs_dat_i;
        end else if (core_gnt) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= ~core_we;
            sram_wmask0 <= core_we ? core_be : '0;
            sram_addr0  <= core_addr;
            sram_din0   <= core_wdata;
        end else begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
        end
    end

    // An abandoned cycle (cyc low in the ack state) completes silently.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= ((state == WB_ACK_WR) | (state == WB_ACK_RD)) & wbs_cyc_i;
            if (state == WB_ACK_RD) begin
                wbs_dat_o <= sram_dout0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            core_rd_p1  <= 1'b0;
            core_rd_p2  <= 1'b0;
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
        end else begin
            core_rd_p1  <= core_gnt & ~core_we;
            core_rd_p2  <= core_rd_p1;
            core_rvalid <= core_rd_p2;
            if (core_rd_p2) begin
                core_rdata <= sram_dout0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_soric_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_soric_sram_arbiter: vectors, corner sequences and a random scoreboard.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_soric_sram_arbiter;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        resetb;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        core_req, core_we;
    logic [3:0]  core_be;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    logic        clear_mem;
    logic [31:0] mem [0:255];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    soric_sram_arbiter dut (
        .wb_clk_i    (clk),
        .resetb      (resetb),
        .wbs_cyc_i   (wbs_cyc),
        .wbs_stb_i   (wbs_stb),
        .wbs_we_i    (wbs_we),
        .wbs_sel_i   (wbs_sel),
        .wbs_adr_i   (wbs_adr),
        .wbs_dat_i   (wbs_dat),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_be     (core_be),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // Behavioural single-port macro: dout valid the cycle after the access.
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat = 0;
        core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    endtask

    task automatic do_reset();
        resetb = 0;
        idle_inputs();
        clear_mem = 1;
        repeat (3) @(negedge clk);
        clear_mem = 0;
        resetb = 1;
        @(negedge clk);
    endtask

    // Starts at a negedge; returns ack status, ack latency in edges, read data.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic acked, output int lat,
                           output logic [31:0] rd, output logic touched);
        acked = 0; lat = 0; rd = '0; touched = 0;
        wbs_cyc = 1; wbs_stb = 1; wbs_we = we; wbs_adr = adr; wbs_dat = dat; wbs_sel = sel;
        for (int i = 1; i <= 20 && !acked; i++) begin
            @(posedge clk); #1;
            if (!sram_csb0) touched = 1;
            if (wbs_ack_o) begin
                acked = 1; lat = i; rd = wbs_dat_o;
            end
        end
        wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rexp_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acked, touched;
        int          lat;
        logic [31:0] rd;

        vecs[0] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 3, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h3000_0010, 32'h0000_AB00, 4'h2, 1'b1, 2, 32'h0};
        vecs[2] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 3, 32'hDEAD_ABEF};
        vecs[3] = '{1'b1, 32'h3000_03FC, 32'h1234_5678, 4'hF, 1'b1, 2, 32'h0};
        vecs[4] = '{1'b0, 32'h3000_03FC, 32'h0,         4'hF, 1'b1, 3, 32'h1234_5678};
        vecs[5] = '{1'b1, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 1'b1, 2, 32'h0};
        vecs[6] = '{1'b1, 32'h3000_0000, 32'h5A5A_5A5A, 4'h9, 1'b1, 2, 32'h0};
        vecs[7] = '{1'b1, 32'h3000_0400, 32'hFFFF_FFFF, 4'hF, 1'b0, 0, 32'h0};
        vecs[8] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b1, 3, 32'h5AA5_A55A};
        vecs[9] = '{1'b0, 32'h2000_0010, 32'h0,         4'hF, 1'b0, 0, 32'h0};

        // Reset values while reset is held
        resetb = 0;
        idle_inputs();
        clear_mem = 1;
        repeat (2) @(negedge clk);
        check("rst_csb0", sram_csb0, 1);
        check("rst_web0", sram_web0, 1);
        check("rst_wmask0", sram_wmask0, 0);
        check("rst_addr0", sram_addr0, 0);
        check("rst_din0", sram_din0, 0);
        check("rst_ack", wbs_ack_o, 0);
        check("rst_wbdat", wbs_dat_o, 0);
        check("rst_rvalid", core_rvalid, 0);
        check("rst_rdata", core_rdata, 0);
        clear_mem = 0;
        resetb = 1;
        @(negedge clk);

        // First WB write with macro-port timing checks
        wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF;
        wbs_adr = 32'h3000_0010; wbs_dat = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("wr_csb0", sram_csb0, 0);
        check("wr_web0", sram_web0, 0);
        check("wr_addr0", sram_addr0, 8'h04);
        check("wr_wmask0", sram_wmask0, 4'hF);
        check("wr_din0", sram_din0, 32'hDEAD_BEEF);
        check("wr_ack_early", wbs_ack_o, 0);
        @(posedge clk); #1;
        check("wr_ack", wbs_ack_o, 1);
        check("wr_csb0_off", sram_csb0, 1);
        wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
        @(posedge clk); #1;
        check("wr_ack_pulse", wbs_ack_o, 0);
        @(negedge clk);

        // Table-driven WB transfers
        for (int i = 0; i < 10; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, acked, lat, rd, touched);
            check($sformatf("vec%0d_ack", i), acked, vecs[i].exp_ack);
            if (vecs[i].exp_ack) begin
                check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
                if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end else begin
                check($sformatf("vec%0d_no_macro", i), touched, 0);
            end
        end

        // Core write then read streams, request held every cycle
        for (int c = 0; c < 4; c++) begin
            core_req = 1; core_we = 1; core_be = 4'hF;
            core_addr = 8'(c); core_wdata = 32'h1000 + c;
            #1;
            check("core_wr_gnt", core_gnt, 1);
            @(negedge clk);
        end
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                core_req = 1; core_we = 0; core_addr = 8'(c);
            end else begin
                core_req = 0;
            end
            #1;
            if (c < 4) check("core_rd_gnt", core_gnt, 1);
            check($sformatf("core_rvalid_c%0d", c), core_rvalid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check("core_rdata", core_rdata, 32'h1000 + c - 3);
            @(negedge clk);
        end

        // Core streaming while a WB read arrives
        begin
            int gnt_low = 0;
            int wb_lat = -1;
            logic [31:0] wb_rd = '0;
            for (int c = 0; c < 12; c++) begin
                if (wbs_ack_o) begin
                    wb_lat = c - 2; wb_rd = wbs_dat_o;
                    wbs_cyc = 0; wbs_stb = 0;
                end
                core_req = 1; core_we = 0; core_addr = 8'(c & 3);
                if (c == 2) begin
                    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h3000_0010;
                end
                #1;
                if (c == 2) check("mix_wb_first", core_gnt, 0);
                if (c == 3) check("mix_core_back", core_gnt, 1);
                if (!core_gnt) gnt_low++;
                @(negedge clk);
            end
            check("mix_gnt_low_cycles", gnt_low, 1);
            check("mix_wb_lat", wb_lat, 3);
            check("mix_wb_rdata", wb_rd, 32'hDEAD_ABEF);
            core_req = 0;
            repeat (4) @(negedge clk);
        end

        // Abort: cyc dropped right after the write is accepted
        wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF;
        wbs_adr = 32'h3000_0020; wbs_dat = 32'h0BAD_F00D;
        @(posedge clk); #1;
        wbs_cyc = 0; wbs_stb = 0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (wbs_ack_o) seen++;
            end
            check("abort_no_ack", seen, 0);
        end
        @(negedge clk);

        // Reset pulsed while a WB read is in WAIT_RD
        wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h3000_03FC;
        @(posedge clk); #1;
        check("rstrd_access", sram_csb0, 0);
        resetb = 0; wbs_cyc = 0; wbs_stb = 0;
        #1;
        check("rstrd_csb0", sram_csb0, 1);
        check("rstrd_web0", sram_web0, 1);
        check("rstrd_addr0", sram_addr0, 0);
        check("rstrd_ack", wbs_ack_o, 0);
        @(negedge clk);
        resetb = 1;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (wbs_ack_o) seen++;
            end
            check("rstrd_no_ack", seen, 0);
        end
        @(negedge clk);
        wb_xfer(1'b0, 32'h3000_03FC, 32'h0, 4'hF, acked, lat, rd, touched);
        check("rstrd_after_ack", acked, 1);
        check("rstrd_after_lat", lat, 3);
        check("rstrd_after_data", rd, 32'h1234_5678);

        // Randomized mixed traffic against a transaction-level model
        do_reset();
        begin
            logic [31:0] shadow [0:15];
            rexp_t       rq [$];
            int          wb_ack_at  = -1;
            int          wb_free_at = 0;
            logic        wb_exp_rd  = 0;
            logic [31:0] wb_exp     = '0;
            logic        wb_on      = 0;
            logic        core_wait  = 0;
            logic        last_wb    = 0;
            localparam int N = 400;
            for (int i = 0; i < 16; i++) shadow[i] = '0;
            for (int t = 0; t < N; t++) begin
                logic exp_rv, wreq, creq, win_core, win_wb;
                exp_rv = (rq.size() > 0) && (rq[0].due == t);
                check("rnd_rvalid", core_rvalid, exp_rv);
                if (exp_rv) begin
                    check("rnd_rdata", core_rdata, rq[0].data);
                    void'(rq.pop_front());
                end
                check("rnd_ack", wbs_ack_o, (t == wb_ack_at));
                if (t == wb_ack_at) begin
                    if (wb_exp_rd) check("rnd_wb_rdata", wbs_dat_o, wb_exp);
                    wbs_cyc = 0; wbs_stb = 0; wb_on = 0;
                end
                if (!core_wait) begin
                    core_req   = (t < N - 8) && ($urandom_range(0, 2) != 0);
                    core_we    = 1'($urandom);
                    core_addr  = 8'($urandom_range(0, 15));
                    core_be    = 4'($urandom);
                    core_wdata = $urandom;
                end
                if (!wb_on && t >= wb_free_at && t < N - 8 && $urandom_range(0, 5) == 0) begin
                    wb_on = 1; wbs_cyc = 1; wbs_stb = 1;
                    wbs_we  = 1'($urandom);
                    wbs_adr = BASE + (32'($urandom_range(0, 15)) << 2);
                    wbs_sel = 4'($urandom);
                    wbs_dat = $urandom;
                end
                #1;
                wreq = wb_on && (t >= wb_free_at);
                creq = core_req;
                win_core = (wreq && creq) ? last_wb : creq;
                win_wb   = wreq && !win_core;
                check("rnd_core_gnt", core_gnt, win_core);
                if (win_core) begin
                    last_wb = 0;
                    if (core_we) begin
                        for (int b = 0; b < 4; b++)
                            if (core_be[b]) shadow[core_addr[3:0]][8*b +: 8] = core_wdata[8*b +: 8];
                    end else begin
                        rq.push_back('{t + 3, shadow[core_addr[3:0]]});
                    end
                end
                if (win_wb) begin
                    last_wb = 1;
                    if (wbs_we) begin
                        for (int b = 0; b < 4; b++)
                            if (wbs_sel[b]) shadow[wbs_adr[5:2]][8*b +: 8] = wbs_dat[8*b +: 8];
                        wb_exp_rd = 0; wb_ack_at = t + 2; wb_free_at = t + 3;
                    end else begin
                        wb_exp = shadow[wbs_adr[5:2]];
                        wb_exp_rd = 1; wb_ack_at = t + 3; wb_free_at = t + 4;
                    end
                end
                core_wait = creq && !win_core;
                @(negedge clk);
            end
            check("rnd_queue_drained", rq.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/soric_sram_arbiter.md
Name: soric_sram_arbiter

Overview:
Shares one single-port SoRIC SRAM macro (OpenRAM-style csb0/web0/wmask0/addr0/din0/dout0) between the Caravel Wishbone slave port and the SoRIC core-side memory port. Arbitrates per macro cycle with round-robin priority and pipelines macro accesses. Converts results into a Wishbone ack/data response and a core rvalid/rdata response. Sits in user_project_wrapper between wbs_* and the SRAM macro.

Parameters:
ADDR_W, 8, macro word-address width (256 x 32-bit words)
DATA_W, 32, data width; byte lanes = DATA_W/8
WB_BASE, 32'h3000_0000, Wishbone base address of the SRAM window
WB_MASK, 32'hFFFF_FC00, address bits compared against WB_BASE for decode

Ports:
wb_clk_i  in  1  single clock for arbiter and macro
resetb  in  1  asynchronous, active-low reset
wbs_cyc_i  in  1  WB cycle
wbs_stb_i  in  1  WB strobe
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  WB byte selects
wbs_adr_i  in  32  WB byte address
wbs_dat_i  in  32  WB write data
wbs_ack_o  out  1  WB ack, one-cycle pulse
wbs_dat_o  out  32  WB read data, valid with ack
core_req  in  1  core request, held until core_gnt
core_we  in  1  core write
core_be  in  4  core byte enables
core_addr  in  ADDR_W  core word address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  combinational grant; request consumed at this edge
core_rvalid  out  1  read data valid pulse
core_rdata  out  DATA_W  read data
sram_csb0  out  1  macro chip select, active low, registered
sram_web0  out  1  macro write enable, active low, registered
sram_wmask0  out  4  macro byte mask, registered
sram_addr0  out  ADDR_W  macro address, registered
sram_din0  out  DATA_W  macro write data, registered
sram_dout0  in  DATA_W  macro read data, valid the cycle after the access cycle

Behaviour:
- Reset (resetb low, async): csb0=1, web0=1, wmask0=0, addr0=0, din0=0, wbs_ack_o=0, wbs_dat_o=0, core_rvalid=0, core_rdata=0, rr pointer=WB-preferred, WB FSM=IDLE. An in-flight access or pending ack is dropped.
- WB hit: cyc&stb&((wbs_adr_i&WB_MASK)==(WB_BASE&WB_MASK)). Word address = wbs_adr_i[ADDR_W+1:2]. A miss is never acked.
- WB FSM states: IDLE, WAIT_RD, ACK_RD, ACK_WR, HOLD.
- IDLE: WB hit counts as a request. If WB wins, load macro regs and go to ACK_WR (write) or WAIT_RD (read).
- ACK_WR: macro write cycle. Assert wbs_ack_o for one cycle, then go to HOLD.
- WAIT_RD: macro read cycle. Go to ACK_RD.
- ACK_RD: wbs_dat_o<=sram_dout0 registered, ack pulses, then go to HOLD.
- HOLD: one cycle so the master can drop stb, then go to IDLE. No WB re-request is possible before IDLE.
- WB latency, stb sampled high at edge E0:
  - write: ack high in cycle after E1
  - read: ack high in cycle after E2
- Core: core_gnt = core_req & macro slot won this cycle. Macro regs are loaded at that edge. For reads, core_rvalid pulses 2 edges after grant edge, with core_rdata = registered sram_dout0. Back-to-back grants every cycle are allowed; rvalid is pipelined, in order.
- Arbitration, once per cycle: the candidates are the WB request (IDLE only) and core_req.
  - Sole requester wins.
  - If both request, the one not granted last wins; the rr pointer updates on every grant.
  - If neither requests, csb0=1 and web0=1 the next cycle.
  - The core may use the macro while WB sits in WAIT_RD/ACK_*/HOLD.
- Write mask: wmask0=sel/be, din0=write data. Reads drive web0=1, wmask0=0.
- cyc dropped mid-transaction (abort): the FSM still completes to HOLD, and the ack is suppressed if cyc is low in the ack cycle.
- Write followed by read to the same address, back-to-back: the macro ordering guarantees the read returns new data. No forwarding is needed.

Decomposition:
- Shared package soric_mem_pkg:
  - SRAM_ADDR_W, SRAM_DATA_W
  - WB FSM state encoding
  - requester-ID constants (REQ_WB=0, REQ_CORE=1)
- One sub-module: soric_rr_arb2, a 2-input round-robin arbiter with a registered last-winner pointer.
- Everything else stays in soric_sram_arbiter.

Test Plan:
- WB write 0x3000_0010 <= 0xDEADBEEF, sel=4'hF:
  - csb0=0, web0=0, addr0=0x04 for one cycle
  - ack one cycle later
  - a later WB read returns 0xDEADBEEF, with ack 3 cycles after stb
- WB write sel=4'b0010 data 0x0000_AB00 over 0xDEADBEEF -> readback 0xDEADABEF.
- Core streams 4 reads, addr 0..3, req held continuously -> gnt 4 consecutive cycles; rvalid on the 4 cycles starting 2 after the first gnt, data in order.
- Core req continuous plus a WB read hit -> WB granted within 2 cycles; core gnt deasserted exactly 1 cycle; grants strictly alternate while both request.
- WB access to 0x3000_0400 (miss) -> no macro access, wbs_ack_o stays 0 for 20 cycles.
- resetb pulsed low during WAIT_RD -> all outputs to reset values immediately, no ack afterwards; after release, a new WB read completes normally.
